// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and RV32 field extractors for the lw_exec load executor.
package calc_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [2:0] F3_W      = 3'b010;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_e;

    function automatic logic [4:0] f_rs1(input logic [31:0] ir);
        return ir[19:15];
    endfunction

    function automatic logic [4:0] f_rs2(input logic [31:0] ir);
        return ir[24:20];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[11:7];
    endfunction

    function automatic logic [31:0] f_imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] f_imm_s(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:25], ir[11:7]};
    endfunction

endpackage

// File: rtl/rv_regfile.sv
// 32xW register file: x0 reads zero, two operand read ports plus a debug read port, one sync write.
module rv_regfile #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   ra1,
    output logic [W-1:0] rd1,
    input  logic [4:0]   ra2,
    output logic [W-1:0] rd2,
    input  logic [4:0]   ra3,
    output logic [W-1:0] rd3,
    input  logic         we,
    input  logic [4:0]   wa,
    input  logic [W-1:0] wd
);

    logic [W-1:0] regs_q [32];
    logic [W-1:0] regs_d [32];

    always_comb begin
        for (int i = 0; i < 32; i++) regs_d[i] = regs_q[i];
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 32; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : regs_q[ra3];

endmodule

// File: rtl/lw_exec.sv
// Multicycle LW executor over a shared word RAM; SW support is added when LW_EXEC_STORE_EN is defined.
module lw_exec
    import calc_pkg::*;
#(
    parameter int W         = 32,
    parameter int AW        = 4,
    parameter int PROG_BASE = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [AW-1:0] mem_addr,
    input  logic [W-1:0]  mem_rdata,
    output logic          mem_we,
    output logic [W-1:0]  mem_wdata,
    input  logic [4:0]    rf_raddr,
    output logic [W-1:0]  rf_rdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [7:0]    retired
);

    state_e        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [W-1:0]  ir_q, ir_d;
    logic [AW-1:0] ea_q, ea_d;
    logic [W-1:0]  mdr_q, mdr_d;
    logic          err_q, err_d;
    logic [7:0]    ret_q, ret_d;

    logic [W-1:0]  rs1_val, rs2_val, imm, ea_full;
    logic          is_lw, is_sw, ea_ok, pc_last, bad_op;

    rv_regfile #(.W(W)) u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (f_rs1(ir_q)),
        .rd1   (rs1_val),
        .ra2   (f_rs2(ir_q)),
        .rd2   (rs2_val),
        .ra3   (rf_raddr),
        .rd3   (rf_rdata),
        .we    (state_q == WB && is_lw),
        .wa    (f_rd(ir_q)),
        .wd    (mdr_q)
    );

    always_comb begin
        is_lw = (ir_q[6:0] == OPC_LOAD) && (ir_q[14:12] == F3_W);
`ifdef LW_EXEC_STORE_EN
        is_sw = (ir_q[6:0] == OPC_STORE) && (ir_q[14:12] == F3_W);
`else
        is_sw = 1'b0;
`endif
        bad_op  = !(is_lw || is_sw);
        imm     = is_sw ? f_imm_s(ir_q) : f_imm_i(ir_q);
        // Base is read here in DECODE, so rd==rs1 sees the pre-load value.
        ea_full = rs1_val + imm;
        ea_ok   = (ea_full[W-1:AW] == '0);
        pc_last = (pc_q == {AW{1'b1}});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= AW'(PROG_BASE);
            ir_q    <= '0;
            ea_q    <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
            ret_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
            ret_q   <= ret_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = DECODE;
            DECODE:  state_d = (ir_q == '0 || bad_op || !ea_ok) ? HALT : MEM;
            MEM:     state_d = WB;
            WB:      state_d = pc_last ? HALT : FETCH;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        ir_d  = ir_q;
        ea_d  = ea_q;
        mdr_d = mdr_q;
        err_d = err_q;
        ret_d = ret_q;
        case (state_q)
            FETCH:  ir_d = mem_rdata;
            DECODE: begin
                ea_d  = ea_full[AW-1:0];
                err_d = (ir_q != '0) && (bad_op || !ea_ok);
            end
            MEM:    mdr_d = mem_rdata;
            WB: begin
                if (ret_q != 8'hFF) ret_d = ret_q + 8'd1;
                // Running off the top of RAM is a fault; the wrapped word is never fetched.
                pc_d  = pc_q + 1'b1;
                err_d = pc_last;
            end
            default: ;
        endcase
    end

    always_comb begin
        mem_addr  = (state_q == MEM) ? ea_q : pc_q;
        mem_we    = (state_q == MEM) && is_sw;
        mem_wdata = mem_we ? rs2_val : '0;
        busy      = (state_q == FETCH) || (state_q == DECODE) ||
                    (state_q == MEM)   || (state_q == WB);
        done      = (state_q == HALT);
        err       = err_q;
        retired   = ret_q;
    end

endmodule

// File: tb/tb_lw_exec.sv
// Directed vector bench for lw_exec: RAM model, program table, plus reset/halt/store sequences.
module tb_lw_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [4:0]  rf_raddr = 5'd0;
    logic [31:0] rf_rdata;
    logic        busy, done, err;
    logic [7:0]  retired;

    logic [31:0] mem [16];
    int          nvec = 0;
    int          nfail = 0;
    int          we_cnt = 0;
    int          cyc = 0;

    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    lw_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .retired   (retired)
    );

    typedef struct {
        string       name;
        logic [31:0] prog [8];
        logic [31:0] data [8];
        int          cyc;
        logic        err;
        logic [7:0]  ret;
        logic [4:0]  ra;
        logic [31:0] va;
        logic [4:0]  rb;
        logic [31:0] vb;
    } vec_t;

    vec_t vq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load(input logic [31:0] prog [8], input logic [31:0] data [8]);
        for (int i = 0; i < 8; i++) begin
            mem[i]     = data[i];
            mem[i + 8] = prog[i];
        end
    endtask

    // Pulses start, then counts edges until done; RAM writes are applied from mem_we here.
    task automatic run_prog(input string nm);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({nm, ".busy"}, 32'(busy), 32'd1);
        cyc = 0;
        we_cnt = 0;
        while (!done && cyc < 60) begin
            if (mem_we) begin
                we_cnt++;
                mem[mem_addr] = mem_wdata;
            end
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic rd_reg(input logic [4:0] r, output logic [31:0] v);
        rf_raddr = r;
        #1 v = rf_rdata;
    endtask

    task automatic add(input string nm, input logic [31:0] p [8], input logic [31:0] d [8],
                       input int c, input logic e, input logic [7:0] rt,
                       input logic [4:0] ra, input logic [31:0] va,
                       input logic [4:0] rb, input logic [31:0] vb);
        vec_t v;
        v.name = nm; v.prog = p; v.data = d; v.cyc = c; v.err = e; v.ret = rt;
        v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
        vq.push_back(v);
    endtask

    logic [31:0] z8 [8];
    logic [31:0] t1p [8];
    logic [31:0] t1d [8];
    logic [31:0] rv;
    logic [7:0]  ret_snap;

    initial begin
        z8  = '{default: 32'h0};
        t1p = '{32'h00102283, 32'h00202303, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        t1d = '{32'h0, 32'd58, 32'd47, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

        add("two_lw", t1p, t1d, 10, 1'b0, 8'd2, 5'd5, 32'd58, 5'd6, 32'd47);
        add("rd_x0", '{32'h00102003, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 6, 1'b0, 8'd1, 5'd0, 32'd0, 5'd5, 32'd0);
        add("ea_oob", '{32'h01002283, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 2, 1'b1, 8'd0, 5'd5, 32'd0, 5'd0, 32'd0);
        add("ea_neg", '{32'hFFF02283, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 2, 1'b1, 8'd0, 5'd5, 32'd0, 5'd0, 32'd0);
        add("rtype", '{32'h00000033, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 2, 1'b1, 8'd0, 5'd5, 32'd0, 5'd0, 32'd0);
        add("lb_f3", '{32'h00100283, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 2, 1'b1, 8'd0, 5'd5, 32'd0, 5'd0, 32'd0);
        add("neg_imm", '{32'h00302083, 32'hFFF0A383, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            '{32'h0, 32'h0, 32'h0, 32'd5, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0},
            10, 1'b0, 8'd2, 5'd1, 32'd5, 5'd7, 32'hDEADBEEF);
        add("rd_eq_rs1", '{32'h00302083, 32'h0000A083, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            '{32'h0, 32'h0, 32'h0, 32'd5, 32'h0, 32'h1234, 32'h0, 32'h0},
            10, 1'b0, 8'd2, 5'd1, 32'h1234, 5'd0, 32'd0);
        add("pc_wrap", '{default: 32'h00002103},
            '{32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            32, 1'b1, 8'd8, 5'd2, 32'h77, 5'd0, 32'd0);
`ifndef LW_EXEC_STORE_EN
        add("sw_unsup", '{32'h005021A3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
            t1d, 2, 1'b1, 8'd0, 5'd5, 32'd0, 5'd0, 32'd0);
`endif

        // Reset state
        load(z8, z8);
        do_reset();
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.err", 32'(err), 32'd0);
        chk("rst.retired", 32'(retired), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.mem_wdata", mem_wdata, 32'd0);
        chk("rst.mem_addr", 32'(mem_addr), 32'd8);
        rd_reg(5'd5, rv);
        chk("rst.x5", rv, 32'd0);

        foreach (vq[k]) begin
            load(vq[k].prog, vq[k].data);
            do_reset();
            run_prog(vq[k].name);
            chk({vq[k].name, ".cycles"}, 32'(cyc), 32'(vq[k].cyc));
            chk({vq[k].name, ".done"}, 32'(done), 32'd1);
            chk({vq[k].name, ".err"}, 32'(err), 32'(vq[k].err));
            chk({vq[k].name, ".retired"}, 32'(retired), 32'(vq[k].ret));
            chk({vq[k].name, ".we_cnt"}, 32'(we_cnt), 32'd0);
            rd_reg(vq[k].ra, rv);
            chk({vq[k].name, ".reg_a"}, rv, vq[k].va);
            rd_reg(vq[k].rb, rv);
            chk({vq[k].name, ".reg_b"}, rv, vq[k].vb);
        end

        // HALT is sticky: start after completion changes nothing
        ret_snap = retired;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (5) @(negedge clk);
        chk("sticky.done", 32'(done), 32'd1);
        chk("sticky.busy", 32'(busy), 32'd0);
        chk("sticky.retired", 32'(retired), 32'(ret_snap));

        // Reset during MEM of the first lw, then full re-run
        load(t1p, t1d);
        do_reset();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.err", 32'(err), 32'd0);
        chk("midrst.retired", 32'(retired), 32'd0);
        chk("midrst.mem_we", 32'(mem_we), 32'd0);
        rd_reg(5'd5, rv);
        chk("midrst.x5", rv, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_prog("rerun");
        chk("rerun.cycles", 32'(cyc), 32'd10);
        chk("rerun.err", 32'(err), 32'd0);
        chk("rerun.retired", 32'(retired), 32'd2);
        rd_reg(5'd5, rv);
        chk("rerun.x5", rv, 32'd58);
        rd_reg(5'd6, rv);
        chk("rerun.x6", rv, 32'd47);

`ifdef LW_EXEC_STORE_EN
        // lw x5,1(x0); sw x5,3(x0); halt
        load('{32'h00102283, 32'h005021A3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, t1d);
        do_reset();
        run_prog("store");
        chk("store.cycles", 32'(cyc), 32'd10);
        chk("store.err", 32'(err), 32'd0);
        chk("store.retired", 32'(retired), 32'd2);
        chk("store.we_cnt", 32'(we_cnt), 32'd1);
        chk("store.mem3", mem[3], 32'd58);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
